// File: rtl/pipeline_stall_controller_pkg.sv
// Shared types and constants for the pipeline stall/flush controller.
// Holds the FSM state encoding and the per-stage write-enable bundle.
package pipeline_stall_controller_pkg;

    typedef enum logic [1:0] {
        S_RUN     = 2'd0,
        S_DM_WAIT = 2'd1,
        S_IM_WAIT = 2'd2
    } state_t;

    typedef struct packed {
        logic pc_we;
        logic if_id_we;
        logic id_ex_we;
        logic ex_mem_we;
        logic mem_wb_we;
    } stage_ctrl_t;

    localparam stage_ctrl_t CTRL_ALL_RUN = 5'b11111;
    localparam stage_ctrl_t CTRL_FREEZE  = 5'b00000;

endpackage

// File: rtl/pipeline_stall_controller_sat_counter.sv
// Saturating up-counter used for the stall and flush performance counters.
// Holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_inc,
    input  logic         i_clear,
    output logic [W-1:0] o_count
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_inc && (r_count != {W{1'b1}})) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/pipeline_stall_controller.sv
// Pipeline freeze/bubble/discard sequencing for the 5-stage core.
// Memory waits override hazards, which override ID-stage redirects.
import pipeline_stall_controller_pkg::*;

module pipeline_stall_controller #(
    parameter int CNT_W      = 32,
    parameter int DM_TIMEOUT = 1024,
    parameter int TO_W       = 11
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ID_Branch_Stall,
    input  logic             ID_LoadUse_Stall,
    input  logic             ID_Redirect,
    input  logic             IM_Ready,
    input  logic             DM_Req,
    input  logic             DM_Ready,
    output logic             PC_Write,
    output logic             IF_ID_Write,
    output logic             IF_ID_Flush,
    output logic             ID_EX_Write,
    output logic             ID_EX_Flush,
    output logic             EX_MEM_Write,
    output logic             MEM_WB_Write,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count,
    output logic             DM_Timeout
);

    localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(DM_TIMEOUT);

    state_t          r_state;
    state_t          w_state_nxt;
    logic            r_discard;
    logic            w_discard_nxt;
    logic [TO_W-1:0] r_wait_cnt;
    logic [TO_W-1:0] w_wait_inc;
    logic            r_timeout;

    logic            w_hazard;
    logic            w_redirect;
    logic            w_dm_wait;
    stage_ctrl_t     w_ctrl;
    logic            w_if_flush;
    logic            w_ex_flush;

    assign w_hazard   = ID_Branch_Stall | ID_LoadUse_Stall;
    // A redirect under a hazard is re-presented once the branch resolves.
    assign w_redirect = ID_Redirect & ~w_hazard;
    assign w_dm_wait  = DM_Req & ~DM_Ready;

    always_comb begin
        w_ctrl        = CTRL_FREEZE;
        w_if_flush    = 1'b0;
        w_ex_flush    = 1'b0;
        w_state_nxt   = r_state;
        w_discard_nxt = r_discard;
        if (w_dm_wait) begin
            w_state_nxt = S_DM_WAIT;
        end else if (IM_Ready) begin
            w_state_nxt   = S_RUN;
            w_ctrl        = CTRL_ALL_RUN;
            w_discard_nxt = 1'b0;
            if (r_discard) begin
                w_if_flush = 1'b1;
            end
            if (w_hazard) begin
                w_ctrl.pc_we = 1'b0;
                w_ex_flush   = 1'b1;
                if (!r_discard) begin
                    w_ctrl.if_id_we = 1'b0;
                end
            end else if (w_redirect) begin
                w_if_flush = 1'b1;
            end
        end else begin
            w_state_nxt  = S_IM_WAIT;
            w_ctrl       = CTRL_ALL_RUN;
            w_ctrl.pc_we = 1'b0;
            if (w_hazard) begin
                w_ctrl.if_id_we = 1'b0;
                w_ex_flush      = 1'b1;
            end else begin
                w_if_flush = 1'b1;
            end
            // Load the target now; the fetch still in flight is dropped later.
            if (w_redirect) begin
                w_ctrl.pc_we  = 1'b1;
                w_discard_nxt = 1'b1;
            end
        end
        if (rst) begin
            w_ctrl     = CTRL_FREEZE;
            w_if_flush = 1'b0;
            w_ex_flush = 1'b0;
        end
    end

    assign w_wait_inc = (r_wait_cnt == {TO_W{1'b1}}) ? r_wait_cnt
                                                     : r_wait_cnt + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_RUN;
            r_discard  <= 1'b0;
            r_wait_cnt <= '0;
            r_timeout  <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_discard <= w_discard_nxt;
            if (w_dm_wait) begin
                r_wait_cnt <= w_wait_inc;
                if (w_wait_inc >= TO_LIMIT) begin
                    r_timeout <= 1'b1;
                end
            end else begin
                r_wait_cnt <= '0;
            end
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_inc   (~w_ctrl.pc_we),
        .i_clear (1'b0),
        .o_count (stall_cycles)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_inc   (w_if_flush),
        .i_clear (1'b0),
        .o_count (flush_count)
    );

    assign PC_Write     = w_ctrl.pc_we;
    assign IF_ID_Write  = w_ctrl.if_id_we;
    assign IF_ID_Flush  = w_if_flush;
    assign ID_EX_Write  = w_ctrl.id_ex_we;
    assign ID_EX_Flush  = w_ex_flush;
    assign EX_MEM_Write = w_ctrl.ex_mem_we;
    assign MEM_WB_Write = w_ctrl.mem_wb_we;
    assign DM_Timeout   = r_timeout;

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Directed table-driven bench for pipeline_stall_controller.
// Expected outputs and counter totals are hand-derived from the vectors.
module tb_pipeline_stall_controller;

    localparam int CNT_W = 32;

    logic clk = 1'b0;
    logic rst;
    logic br, lu, rd, im, dq, dr;
    logic pc_w, ifid_w, ifid_f, idex_w, idex_f, exmem_w, memwb_w;
    logic [CNT_W-1:0] stall_cycles, flush_count;
    logic dm_to;

    int n_checks = 0;
    int n_fail   = 0;

    // exp bit order: PC_W, IF_ID_W, IF_ID_F, ID_EX_W, ID_EX_F, EX_MEM_W, MEM_WB_W
    typedef struct {
        logic       br, lu, rd, im, dq, dr;
        logic [6:0] exp;
    } vec_t;

    vec_t tv[18];

    always #5 clk = ~clk;

    pipeline_stall_controller #(
        .CNT_W      (CNT_W),
        .DM_TIMEOUT (1024),
        .TO_W       (11)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .ID_Branch_Stall  (br),
        .ID_LoadUse_Stall (lu),
        .ID_Redirect      (rd),
        .IM_Ready         (im),
        .DM_Req           (dq),
        .DM_Ready         (dr),
        .PC_Write         (pc_w),
        .IF_ID_Write      (ifid_w),
        .IF_ID_Flush      (ifid_f),
        .ID_EX_Write      (idex_w),
        .ID_EX_Flush      (idex_f),
        .EX_MEM_Write     (exmem_w),
        .MEM_WB_Write     (memwb_w),
        .stall_cycles     (stall_cycles),
        .flush_count      (flush_count),
        .DM_Timeout       (dm_to)
    );

    function automatic logic [6:0] outs();
        return {pc_w, ifid_w, ifid_f, idex_w, idex_f, exmem_w, memwb_w};
    endfunction

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic b, l, r, i, q, d);
        br = b; lu = l; rd = r; im = i; dq = q; dr = d;
    endtask

    int exp_stall;
    int exp_flush;

    initial begin
        tv[0]  = '{0, 0, 0, 1, 0, 0, 7'b1101011};
        tv[1]  = '{1, 0, 0, 1, 0, 1, 7'b0001111};
        tv[2]  = '{1, 0, 0, 1, 0, 1, 7'b0001111};
        tv[3]  = '{0, 0, 1, 1, 0, 1, 7'b1111011};
        tv[4]  = '{0, 1, 1, 1, 0, 1, 7'b0001111};
        tv[5]  = '{0, 0, 0, 1, 1, 0, 7'b0000000};
        tv[6]  = '{0, 0, 0, 1, 1, 0, 7'b0000000};
        tv[7]  = '{0, 0, 0, 1, 1, 0, 7'b0000000};
        tv[8]  = '{0, 0, 0, 1, 1, 1, 7'b1101011};
        tv[9]  = '{0, 0, 0, 0, 0, 1, 7'b0111011};
        tv[10] = '{0, 0, 1, 0, 0, 1, 7'b1111011};
        tv[11] = '{0, 0, 1, 0, 0, 1, 7'b1111011};
        tv[12] = '{0, 0, 0, 0, 0, 1, 7'b0111011};
        tv[13] = '{0, 0, 0, 1, 0, 1, 7'b1111011};
        tv[14] = '{0, 0, 0, 1, 0, 1, 7'b1101011};
        tv[15] = '{0, 1, 0, 0, 0, 1, 7'b0001111};
        tv[16] = '{0, 0, 0, 0, 1, 0, 7'b0000000};
        tv[17] = '{0, 0, 0, 1, 1, 1, 7'b1101011};

        rst = 1'b1;
        drive(0, 0, 0, 1, 0, 1);
        #12;
        check("reset_outs", 64'(outs()), 64'd0);
        check("reset_stall", 64'(stall_cycles), 64'd0);
        check("reset_flush", 64'(flush_count), 64'd0);
        check("reset_timeout", 64'(dm_to), 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        exp_stall = 0;
        exp_flush = 0;
        for (int k = 0; k < 18; k++) begin
            drive(tv[k].br, tv[k].lu, tv[k].rd, tv[k].im, tv[k].dq, tv[k].dr);
            @(negedge clk);
            check($sformatf("vec%0d_outs", k), 64'(outs()), 64'(tv[k].exp));
            exp_stall += tv[k].exp[6] ? 0 : 1;
            exp_flush += tv[k].exp[4] ? 1 : 0;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_stall", k), 64'(stall_cycles), 64'(exp_stall));
            check($sformatf("vec%0d_flush", k), 64'(flush_count), 64'(exp_flush));
        end
        check("table_stall_total", 64'(stall_cycles), 64'd10);
        check("table_flush_total", 64'(flush_count), 64'd6);
        check("no_timeout_yet", 64'(dm_to), 64'd0);

        drive(0, 0, 0, 1, 1, 0);
        repeat (1023) @(posedge clk);
        #1 check("timeout_1023", 64'(dm_to), 64'd0);
        @(posedge clk);
        #1 check("timeout_1024", 64'(dm_to), 64'd1);
        drive(0, 0, 0, 1, 1, 1);
        @(negedge clk);
        check("dm_release_outs", 64'(outs()), 64'b1101011);
        @(posedge clk);
        #1 check("timeout_sticky", 64'(dm_to), 64'd1);
        check("stall_after_wait", 64'(stall_cycles), 64'(10 + 1024));

        drive(0, 0, 0, 1, 1, 0);
        repeat (3) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("midwait_rst_timeout", 64'(dm_to), 64'd0);
        check("midwait_rst_stall", 64'(stall_cycles), 64'd0);
        check("midwait_rst_flush", 64'(flush_count), 64'd0);
        check("midwait_rst_outs", 64'(outs()), 64'd0);
        drive(0, 0, 0, 1, 0, 1);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("post_rst_outs", 64'(outs()), 64'b1101011);
        @(posedge clk);
        #1 check("post_rst_stall", 64'(stall_cycles), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pipeline_stall_controller.md
Name: pipeline_stall_controller

Overview:
- Consumes hazard requests from the ID forwarding/stall logic (ID_Branch_Stall, load-use stall) and the ID-stage redirect produced by the branch comparator and JALR target adder.
- Also consumes instruction/data memory ready handshakes.
- Turns these into per-stage pipeline-register write enables and flush controls.
- Sits beside the 5-stage datapath and owns all freeze, bubble and discard sequencing, plus stall/flush performance counters.

Parameters:
- CNT_W, 32, width of the stall_cycles and flush_count performance counters (saturating).
- DM_TIMEOUT, 1024, DM_WAIT cycle count at which the sticky DM_Timeout flag is raised.
- TO_W, 11, width of the DM wait counter; must satisfy 2^TO_W > DM_TIMEOUT.

Ports:
- clk  input  1  core clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- ID_Branch_Stall  input  1  branch/JALR operand not yet available.
- ID_LoadUse_Stall  input  1  load-use hazard on an EX-stage consumer.
- ID_Redirect  input  1  branch taken or JALR resolved in ID; PC mux selects target.
- IM_Ready  input  1  instruction fetch for the current PC completes this cycle.
- DM_Req  input  1  MEM stage holds a load/store.
- DM_Ready  input  1  data memory completes the MEM-stage access this cycle.
- PC_Write  output  1  PC register load enable.
- IF_ID_Write  output  1  IF/ID register load enable.
- IF_ID_Flush  output  1  load NOP into IF/ID; only meaningful when IF_ID_Write=1.
- ID_EX_Write  output  1  ID/EX register load enable.
- ID_EX_Flush  output  1  load bubble into ID/EX (control bits zeroed).
- EX_MEM_Write  output  1  EX/MEM register load enable.
- MEM_WB_Write  output  1  MEM/WB register load enable.
- stall_cycles  output  CNT_W  count of cycles with PC_Write=0 after reset.
- flush_count  output  CNT_W  count of cycles with IF_ID_Flush=1.
- DM_Timeout  output  1  sticky; set when DM_WAIT lasts DM_TIMEOUT cycles.

Behaviour:
- Reset (rst=1, asynchronous):
  - state=RUN, discard=0, wait counter=0, stall_cycles=0, flush_count=0, DM_Timeout=0.
  - While rst is high: all *_Write=0 and all flushes=0.
  - Reset mid-wait abandons the wait; the outstanding memory transaction is the memory's responsibility.
- Signal definition: hazard = ID_Branch_Stall | ID_LoadUse_Stall.
- ID_Redirect is qualified only when hazard=0. An unqualified redirect is ignored, because the stalled branch re-presents it.
- Memory handshakes take priority over hazards, and hazards take priority over redirects.
- States: RUN, DM_WAIT, IM_WAIT. The discard flag is an independent register.
- Data-memory wait (any state): if DM_Req=1 and DM_Ready=0:
  - All *_Write=0 and all flushes=0.
  - Next state is DM_WAIT.
  - The wait counter increments.
- DM_WAIT:
  - Outputs are frozen exactly as above until DM_Ready=1.
  - In the DM_Ready=1 cycle, outputs are evaluated as in RUN or IM_WAIT according to IM_Ready. Next state follows those rules; the wait counter clears.
  - When the wait counter reaches DM_TIMEOUT, DM_Timeout=1; it stays set until reset.
- RUN / IM_Ready=1, with discard=0:
  - If hazard: PC_Write=0, IF_ID_Write=0, ID_EX_Flush=1; downstream writes=1.
  - Else if redirect: all writes=1, IF_ID_Flush=1.
  - Else: all writes=1, no flush.
- Any state with IM_Ready=1 and discard=1: the returning instruction is stale.
  - IF_ID_Write=1, IF_ID_Flush=1, PC_Write=1; discard clears.
  - Hazard and redirect rules still apply to ID/EX and to PC_Write.
- RUN or IM_WAIT with IM_Ready=0 → next state IM_WAIT:
  - PC_Write=0. ID is allowed to drain.
  - If hazard: IF_ID_Write=0, ID_EX_Flush=1.
  - Otherwise: IF_ID_Write=1 with IF_ID_Flush=1, inserting a bubble into ID.
  - If redirect is qualified: PC_Write=1 to load the target, and discard is set so the in-flight fetch is dropped.
  - A second redirect while discard=1 keeps discard=1; it never counts twice.
- Leaving IM_WAIT: in the cycle IM_Ready=1, outputs follow the RUN rules (with the discard rule if discard=1), and next state is RUN.
- Counters:
  - Each counter increments by 1 per qualifying cycle and saturates at all-ones.
  - No counter increments while rst is high.
- Outputs are combinational from the current state and inputs. No output depends combinationally on itself; there are no loops through PC_Write.

Decomposition:
- A shared package holds:
  - the state enum (RUN, DM_WAIT, IM_WAIT; 2-bit);
  - the 5-bit stage-control struct: PC/IF_ID/ID_EX/EX_MEM/MEM_WB write bits;
  - the constants CTRL_ALL_RUN and CTRL_FREEZE.
- One sub-module, sat_counter (parameter W, inputs inc and clear), is instantiated twice for stall_cycles and flush_count.

Test Plan:
- ID_Branch_Stall=1 for 2 cycles with IM_Ready=DM_Ready=1 → PC_Write=0, IF_ID_Write=0, ID_EX_Flush=1 for exactly 2 cycles; stall_cycles=2.
- ID_Redirect=1 for one cycle with no hazard → IF_ID_Flush=1 and PC_Write=1 that cycle; flush_count=1.
- ID_Redirect=1 together with ID_LoadUse_Stall=1 → redirect is ignored: IF_ID_Flush=0, ID_EX_Flush=1, flush_count unchanged.
- DM_Req=1 and DM_Ready=0 for 3 cycles, then DM_Ready=1 → all writes=0 for 3 cycles, all 1 on the 4th; stall_cycles=3.
- IM_Ready=0 for 4 cycles, ID_Redirect=1 in the 2nd cycle, then IM_Ready=1:
  - PC_Write=1 only in the redirect cycle.
  - The arriving instruction is flushed (IF_ID_Flush=1) and discard clears.
  - The next IM_Ready=1 cycle is normal.
- DM_Ready held 0 for DM_TIMEOUT=1024 cycles → DM_Timeout=1 and stays 1 after DM_Ready=1. Asserting rst mid-DM_WAIT clears the flag, the counters and the state immediately.
